// File: rtl/add_sub_serial_pkg.sv
// Shared types and constants for the bit-serial adder-subtractor.
package add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

endpackage

// File: rtl/add_sub_fa_cell.sv
// Combinational 1-bit full adder; the only arithmetic cell in the serial datapath.
module add_sub_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
    end

endmodule

// File: rtl/add_sub_serial.sv
// Bit-serial WIDTH-bit adder-subtractor: one bit per clock, LSB first, through a single full-adder cell.
module add_sub_serial
    import add_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               c_msb_in_q, c_msb_in_d;
    logic               fa_s;
    logic               fa_cout;

    add_sub_fa_cell u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        s_d        = s_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        c_msb_in_d = c_msb_in_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d     = {fa_s, s_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                // carry_q at this point is the carry into the MSB cell
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    c_msb_in_d = carry_q;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            s_q        <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            c_msb_in_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            s_q        <= s_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            c_msb_in_q <= c_msb_in_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        sum       = s_q;
        cout      = carry_q;
        ovf       = c_msb_in_q ^ carry_q;
    end

endmodule

// File: tb/tb_add_sub_serial.sv
// Scoreboard bench for add_sub_serial: expected results queued at accept, compared at output handshake.
module tb_add_sub_serial;

    localparam int unsigned W = 4;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } result_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    result_t     sb_q[$];

    add_sub_serial #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Independent model: plain integer add, overflow from operand/result sign bits.
    function automatic result_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        result_t        r;
        logic [W-1:0]   yy;
        logic [W:0]     full;
        yy     = y ^ {W{s}};
        full   = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s};
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        int unsigned guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        check("in_ready_before_accept", in_ready, 1);
        a        = x;
        b        = y;
        sub      = s;
        in_valid = 1'b1;
        tick();
        sb_q.push_back(model(x, y, s));
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        sub      = 1'($urandom);
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                          input int unsigned bp_cycles);
        int unsigned lat;
        result_t     e;
        issue(x, y, s);
        lat = 1;
        while (!out_valid && lat < 30) begin
            check("in_ready_low_run", in_ready, 0);
            tick();
            lat++;
        end
        check("latency", lat, W + 1);
        if (sb_q.size() == 0) begin
            check("scoreboard_nonempty", 0, 1);
            return;
        end
        e = sb_q.pop_front();
        check("sum", sum, e.sum);
        check("cout", cout, e.cout);
        check("ovf", ovf, e.ovf);
        check("in_ready_low_done", in_ready, 0);
        for (int i = 0; i < int'(bp_cycles); i++) begin
            in_valid = ~in_valid;
            a        = W'($urandom);
            b        = W'($urandom);
            sub      = 1'($urandom);
            tick();
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_sum", sum, e.sum);
            check("bp_cout", cout, e.cout);
            check("bp_ovf", ovf, e.ovf);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_after_hs", out_valid, 0);
        check("in_ready_after_hs", in_ready, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        tick();

        run_op(4'b1010, 4'b1010, 1'b0, 0);
        run_op(4'b1010, 4'b1010, 1'b1, 0);
        run_op(4'b0110, 4'b0011, 1'b0, 6);
        run_op(4'b0110, 4'b0011, 1'b1, 0);
        run_op(4'b0011, 4'b0110, 1'b1, 1);
        run_op(4'b1000, 4'b0001, 1'b1, 0);
        run_op(4'b0111, 4'b0001, 1'b0, 0);

        // Reset during the 2nd RUN cycle discards the operation.
        issue(4'b1111, 4'b0001, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sum", sum, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_cout", cout, 0);
        void'(sb_q.pop_back());
        tick();
        rst_n = 1'b1;
        tick();
        run_op(4'b0110, 4'b0011, 1'b0, 0);

        for (int i = 0; i < 16; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 2));
        end

        check("scoreboard_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/add_sub_serial.md
# add_sub_serial

Bit-serial 4-bit binary adder-subtractor, the sequential counterpart of the combinational adder-subtractor. It accepts a parallel operand pair through a valid/ready handshake and processes one bit per clock, LSB first, through a single full-adder cell. It returns a parallel result through a second valid/ready handshake. It sits between the operand source and the result consumer wherever area matters more than latency.

## Interface
Parameters:
- WIDTH, 4, operand and result width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair and sub are valid.
- in_ready  output  1  block can accept an operation; high only in IDLE.
- a  input  WIDTH  minuend / augend.
- b  input  WIDTH  subtrahend / addend.
- sub  input  1  0 = a+b, 1 = a−b (acts as cin, same as the combinational block).
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result bits.
- cout  output  1  carry out of the MSB; for subtraction, 1 = no borrow (a ≥ b unsigned).
- ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. When in_valid && in_ready, a is captured into shift register A. b XOR {WIDTH{sub}} is captured into shift register B. The carry flop is loaded with sub, the bit counter is cleared to 0, and the state moves to RUN.
- RUN: each cycle the cell adds A[0] + B[0] + carry. The sum bit shifts into the MSB of result register S, A and B shift right, carry updates, and the counter increments.
  - The carry into the MSB is latched as c_msb_in when counter = WIDTH−1.
  - After the cycle with counter = WIDTH−1, the state moves to DONE.
- DONE: out_valid=1. sum=S, cout=carry, ovf=c_msb_in XOR carry. All three are held stable until out_valid && out_ready, after which the state returns to IDLE.
- in_valid is ignored outside IDLE. The operand inputs are sampled only on the accept edge, so later changes have no effect.
- Arithmetic is modulo 2^WIDTH. Results are identical to the combinational adder-subtractor for the same a, b, cin.

## Timing
- Reset value of every output: in_ready=1, out_valid=0, sum=0, cout=0, ovf=0.
- Reset clears all registers and the state goes to IDLE, including when reset is asserted mid-RUN or in DONE. The in-flight operation is discarded with no partial result.
- Latency: accept edge to out_valid high is WIDTH+1 cycles (1 load + WIDTH RUN − … counted as: cycle of accept → WIDTH RUN cycles → DONE).
- out_valid and in_ready are never high in the same cycle. Minimum issue interval is WIDTH+2 cycles with out_ready held high.
- Simultaneous in_valid in DONE is ignored. The operand must be re-presented once in_ready rises, one cycle after the output handshake.
- out_valid, once high, does not drop until accepted. Result bits do not change while out_valid=1 && out_ready=0.
- in_ready and out_valid are decoded combinationally from registered state only, never from inputs.

## Structure
- Package add_sub_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - the default WIDTH constant;
  - the counter width $clog2(WIDTH).
- One sub-module, add_sub_fa_cell: a combinational 1-bit full adder (a, b, cin → s, cout). It is instantiated once.
- The top level holds the FSM, the shift registers, the counter, and the carry/c_msb_in flops.

## Test plan
- 1010 + 1010, sub=0 → after 5 cycles sum=0100, cout=1, ovf=1.
- 1010 − 1010, sub=1 → sum=0000, cout=1, ovf=0.
- 0110 + 0011, sub=0 → sum=1001, cout=0, ovf=1.
- 0110 − 0011 → sum=0011, cout=1, ovf=0. Then 0011 − 0110 → sum=1101, cout=0, ovf=0.
- Backpressure: hold out_ready=0 for 6 cycles in DONE.
  - Expect out_valid=1 and sum/cout/ovf stable throughout, with in_ready=0.
  - Toggle in_valid with new operands during this window; expect no effect.
- Reset mid-op: assert rst_n=0 during the 2nd RUN cycle → immediately out_valid=0, sum=0, in_ready=1. A fresh 0110+0011 then completes normally with sum=1001.
